// File: rtl/pronoc_pkg.sv
// NoC-wide shared definitions: injection-arbiter FSM state type and the
// per-configuration flit width / VC count lookup selected by NOC_ID.
package pronoc_pkg;

  // Injection arbiter FSM: IDLE arbitrates headers, LOCK follows one owner's packet.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } inj_arb_state_t;

  // Flit payload width for each supported NoC configuration.
  function automatic int noc_fw(input int noc_id);
    case (noc_id)
      1:       return 64;
      2:       return 128;
      default: return 32;
    endcase
  endfunction

  // Virtual-channel count for each supported NoC configuration.
  function automatic int noc_v(input int noc_id);
    case (noc_id)
      1:       return 4;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inj_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the requester after the
// last one granted. The pointer moves only when i_update_en is asserted.
module inj_rr_arbiter
  import pronoc_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = clog2_min1(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_update_en,
  output logic [NREQ-1:0] o_grant
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;
  logic [PW:0]   w_idx_ext;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Scan requesters starting at the pointer, wrapping at NREQ; first hit wins.
  always_comb begin
    o_grant    = '0;
    w_ptr_next = r_ptr;
    w_found    = 1'b0;
    w_idx_ext  = '0;
    w_idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx_ext = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx_ext >= (PW+1)'(NREQ)) begin
        w_idx_ext = w_idx_ext - (PW+1)'(NREQ);
      end
      w_idx = w_idx_ext[PW-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        w_ptr_next     = (w_idx == PW'(NREQ - 1)) ? '0 : (w_idx + 1'b1);
      end
    end
  end

  // Priority pointer: requester 0 first after reset, advanced on header grants.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_update_en) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/noc_inj_arbiter.sv
// Endpoint injection arbiter: NREQ requesters share one router local port.
// Headers are arbitrated round-robin; a multi-flit packet locks the port to its
// owner until its tail is accepted. Per-VC credit counters gate every send.
// Optional feature macro: NOC_INJ_ARB_STATS_EN adds per-requester packet counters
// on output pkt_cnt.
//
// Handshake: req_ready[i] is combinational from the current inputs and state;
// a flit of requester i transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high, and appears on flit_wr/flit_out one cycle later.
// At most one req_ready bit is high in any cycle; req_ready is low in reset.
module noc_inj_arbiter
  import pronoc_pkg::*;
#(
  parameter  int NOC_ID = 0,
  parameter  int NREQ   = 4,
  parameter  int B      = 4,
  localparam int FW     = noc_fw(NOC_ID),
  localparam int V      = noc_v(NOC_ID),
  localparam int VW     = clog2_min1(V),
  localparam int CW     = $clog2(B + 1),
  localparam int PW     = clog2_min1(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_hdr,
  input  logic [NREQ-1:0]      req_tail,
  input  logic [NREQ*VW-1:0]   req_vc,
  input  logic [NREQ*FW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 flit_wr,
  output logic [FW-1:0]        flit_out,
  output logic                 flit_hdr_o,
  output logic                 flit_tail_o,
  output logic [V-1:0]         flit_vc,
  input  logic [V-1:0]         credit_in,
  output logic                 err_o,
  output inj_arb_state_t       dbg_state_o,
  output logic [V*CW-1:0]      dbg_credit_o
`ifdef NOC_INJ_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]   pkt_cnt
`endif
);

  inj_arb_state_t r_state;
  inj_arb_state_t w_state_next;
  logic [PW-1:0]  r_owner;
  logic [VW-1:0]  r_lock_vc;
  logic [CW-1:0]  r_credit [V];
  logic [CW-1:0]  w_credit_next [V];
  logic           r_err;

  logic [V-1:0]    w_has_credit;
  logic [VW-1:0]   w_req_vc [NREQ];
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_arb_req;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_grant_idx;

  logic            w_send;
  logic [PW-1:0]   w_send_idx;
  logic [VW-1:0]   w_send_vc;
  logic [V-1:0]    w_send_vc_oh;
  logic            w_send_hdr;
  logic            w_send_tail;
  logic            w_hdr_grant;
  logic            w_proto_err;
  logic            w_credit_err;
  logic [V-1:0]    w_dec;

  // Credit availability per VC.
  always_comb begin
    for (int v = 0; v < V; v++) begin
      w_has_credit[v] = (r_credit[v] != '0);
    end
  end

  // Header eligibility: valid header whose target VC has at least one credit.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_req_vc[i] = req_vc[i*VW +: VW];
      for (int v = 0; v < V; v++) begin
        if (w_req_vc[i] == VW'(v) && w_has_credit[v] && req_valid[i] && req_hdr[i]) begin
          w_elig[i] = 1'b1;
        end
      end
    end
  end

  assign w_arb_req = (r_state == IDLE) ? w_elig : '0;

  inj_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req       (w_arb_req),
    .i_update_en (w_hdr_grant),
    .o_grant     (w_grant)
  );

  // One-hot grant to index.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_grant_idx = PW'(i);
    end
  end

  // FSM next state, acceptance and protocol-error detection.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    w_send       = 1'b0;
    w_send_idx   = '0;
    w_send_vc    = '0;
    w_send_hdr   = 1'b0;
    w_send_tail  = 1'b0;
    w_hdr_grant  = 1'b0;
    w_proto_err  = 1'b0;
    if (!reset) begin
      unique case (r_state)
        IDLE: begin
          w_proto_err = |(req_valid & ~req_hdr);
          if (|w_grant) begin
            req_ready   = w_grant;
            w_send      = 1'b1;
            w_send_idx  = w_grant_idx;
            w_send_vc   = w_req_vc[w_grant_idx];
            w_send_hdr  = 1'b1;
            w_send_tail = req_tail[w_grant_idx];
            w_hdr_grant = 1'b1;
            if (!req_tail[w_grant_idx]) w_state_next = LOCK;
          end
        end
        LOCK: begin
          // A stray header inside a packet is flagged but still forwarded.
          w_proto_err = req_valid[r_owner] & req_hdr[r_owner];
          if (req_valid[r_owner] && w_has_credit[r_lock_vc]) begin
            req_ready[r_owner] = 1'b1;
            w_send             = 1'b1;
            w_send_idx         = r_owner;
            w_send_vc          = r_lock_vc;
            w_send_hdr         = req_hdr[r_owner];
            w_send_tail        = req_tail[r_owner];
            if (req_tail[r_owner]) w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // VC of the sent flit as one-hot, and the per-VC decrement vector.
  always_comb begin
    for (int v = 0; v < V; v++) begin
      w_send_vc_oh[v] = (w_send_vc == VW'(v));
    end
    w_dec = w_send_vc_oh & {V{w_send}};
  end

  // Credit update: send and return in the same cycle cancel; over/underflow saturates.
  always_comb begin
    w_credit_err = 1'b0;
    for (int v = 0; v < V; v++) begin
      w_credit_next[v] = r_credit[v];
      if (credit_in[v] && !w_dec[v]) begin
        if (r_credit[v] == CW'(B)) w_credit_err = 1'b1;
        else                       w_credit_next[v] = r_credit[v] + 1'b1;
      end else if (w_dec[v] && !credit_in[v]) begin
        if (r_credit[v] == '0) w_credit_err = 1'b1;
        else                   w_credit_next[v] = r_credit[v] - 1'b1;
      end
    end
  end

  // FSM state and packet ownership registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_lock_vc <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hdr_grant && !w_send_tail) begin
        r_owner   <= w_send_idx;
        r_lock_vc <= w_send_vc;
      end
    end
  end

  // Registered flit output toward the router local port.
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_wr     <= 1'b0;
      flit_out    <= '0;
      flit_hdr_o  <= 1'b0;
      flit_tail_o <= 1'b0;
      flit_vc     <= '0;
    end else begin
      flit_wr <= w_send;
      if (w_send) begin
        flit_out    <= req_data[w_send_idx*FW +: FW];
        flit_hdr_o  <= w_send_hdr;
        flit_tail_o <= w_send_tail;
        flit_vc     <= w_send_vc_oh;
      end
    end
  end

  // Credit counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < V; v++) r_credit[v] <= CW'(B);
      r_err <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) r_credit[v] <= w_credit_next[v];
      r_err <= r_err | w_proto_err | w_credit_err;
    end
  end

  assign err_o       = r_err;
  assign dbg_state_o = r_state;

  for (genvar v = 0; v < V; v++) begin : g_dbg_credit
    assign dbg_credit_o[v*CW +: CW] = r_credit[v];
  end

`ifdef NOC_INJ_ARB_STATS_EN
  logic [31:0] r_pkt_cnt [NREQ];

  // Packets granted per requester; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) r_pkt_cnt[i] <= '0;
    end else if (w_hdr_grant) begin
      r_pkt_cnt[w_send_idx] <= r_pkt_cnt[w_send_idx] + 32'd1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_pkt_cnt
    assign pkt_cnt[i*32 +: 32] = r_pkt_cnt[i];
  end
`endif

endmodule

// File: tb/tb_noc_inj_arbiter.sv
// Bench for noc_inj_arbiter (NOC_ID=0: Fw=32, V=2; NREQ=4; B=4).
// Directed vectors; expected flits are queued at stimulus time and a negedge
// monitor pops and compares them whenever flit_wr is high.
module tb_noc_inj_arbiter;
  import pronoc_pkg::*;

  localparam int NREQ = 4;
  localparam int FW   = 32;
  localparam int V    = 2;
  localparam int CW   = 3;
  localparam int W    = FW + 2 + V;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_hdr = '0;
  logic [NREQ-1:0]      req_tail = '0;
  logic [NREQ-1:0]      req_vc = '0;
  logic [NREQ*FW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 flit_wr;
  logic [FW-1:0]        flit_out;
  logic                 flit_hdr_o;
  logic                 flit_tail_o;
  logic [V-1:0]         flit_vc;
  logic [V-1:0]         credit_in = '0;
  logic                 err_o;
  inj_arb_state_t       dbg_state_o;
  logic [V*CW-1:0]      dbg_credit_o;
`ifdef NOC_INJ_ARB_STATS_EN
  logic [NREQ*32-1:0]   pkt_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_exp;
  logic         prev_ready_any = 1'b0;
  logic         prev_reset = 1'b1;

  noc_inj_arbiter #(.NOC_ID(0), .NREQ(NREQ), .B(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_hdr      (req_hdr),
    .req_tail     (req_tail),
    .req_vc       (req_vc),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .flit_wr      (flit_wr),
    .flit_out     (flit_out),
    .flit_hdr_o   (flit_hdr_o),
    .flit_tail_o  (flit_tail_o),
    .flit_vc      (flit_vc),
    .credit_in    (credit_in),
    .err_o        (err_o),
    .dbg_state_o  (dbg_state_o),
    .dbg_credit_o (dbg_credit_o)
`ifdef NOC_INJ_ARB_STATS_EN
    ,
    .pkt_cnt      (pkt_cnt)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver helpers.
  task automatic set_req(input int i, input logic v, input logic h, input logic t,
                         input logic vc, input logic [FW-1:0] d);
    req_valid[i]        = v;
    req_hdr[i]          = h;
    req_tail[i]         = t;
    req_vc[i]           = vc;
    req_data[i*FW +: FW] = d;
  endtask

  task automatic clr_req(input int i);
    set_req(i, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic push_exp(input logic vc, input logic h, input logic t, input logic [FW-1:0] d);
    logic [V-1:0] oh;
    oh = vc ? 2'b10 : 2'b01;
    exp_q.push_back({oh, h, t, d});
  endtask

  // One clock: check req_ready at negedge, then land at posedge+1 for the next drive.
  task automatic cycle(input logic [NREQ-1:0] exp_rdy, input string name);
    @(negedge clk);
    check(name, req_ready, exp_rdy);
    @(posedge clk);
    #1;
  endtask

  // Monitor: flit_wr follows acceptance by one cycle; flit contents come from exp_q.
  always @(negedge clk) begin
    check("flit_wr_timing", flit_wr, prev_ready_any && !prev_reset);
    if (flit_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL flit_unexpected: got %0h, expected no flit", flit_out);
      end else begin
        m_exp = exp_q.pop_front();
        check("flit", {flit_vc, flit_hdr_o, flit_tail_o, flit_out}, m_exp);
      end
    end
    prev_ready_any = |req_ready;
    prev_reset     = reset;
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_flit_wr", flit_wr, 1'b0);
    check("rst_flit_out", flit_out, 32'h0);
    check("rst_flit_vc", flit_vc, 2'b00);
    check("rst_err", err_o, 1'b0);
    check("rst_state", dbg_state_o, IDLE);
    check("rst_credit", dbg_credit_o, 6'o44);
    reset = 1'b0;

    // Four single-flit headers on VC0: grants 0,1,2,3 then credit stall.
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA000_0000 + i);
      push_exp(1'b0, 1'b1, 1'b1, 32'hA000_0000 + i);
    end
    cycle(4'b0001, "t1_grant0"); clr_req(0);
    cycle(4'b0010, "t1_grant1"); clr_req(1);
    cycle(4'b0100, "t1_grant2"); clr_req(2);
    cycle(4'b1000, "t1_grant3"); clr_req(3);
    check("t1_credit_zero", dbg_credit_o, 6'o40);
    set_req(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA000_00FF);
    cycle(4'b0000, "t1_stall_a");
    cycle(4'b0000, "t1_stall_b");
    clr_req(0);
    credit_in = 2'b01;
    for (int k = 0; k < 4; k++) cycle(4'b0000, "t1_credit_ret");
    credit_in = 2'b00;
    check("t1_credit_back", dbg_credit_o, 6'o44);

    // Requester 2 sends 3 flits on VC1; requester 0 waits for the tail.
    set_req(2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB200_0001);
    push_exp(1'b1, 1'b1, 1'b0, 32'hB200_0001);
    cycle(4'b0100, "t2_hdr");
    set_req(2, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB200_0002);
    set_req(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB000_0001);
    push_exp(1'b1, 1'b0, 1'b0, 32'hB200_0002);
    cycle(4'b0100, "t2_body");
    set_req(2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB200_0003);
    push_exp(1'b1, 1'b0, 1'b1, 32'hB200_0003);
    cycle(4'b0100, "t2_tail");
    clr_req(2);
    push_exp(1'b0, 1'b1, 1'b1, 32'hB000_0001);
    cycle(4'b0001, "t2_req0_after");
    clr_req(0);
    check("t2_err", err_o, 1'b0);
    check("t2_state", dbg_state_o, IDLE);
    check("t2_credit", dbg_credit_o, 6'o13);

    // VC1 credit runs out mid-packet; one credit lets exactly one flit through.
    set_req(1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC100_0001);
    push_exp(1'b1, 1'b1, 1'b0, 32'hC100_0001);
    cycle(4'b0010, "t3_hdr");
    check("t3_state_lock", dbg_state_o, LOCK);
    check("t3_credit0", dbg_credit_o, 6'o03);
    set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC100_0002);
    cycle(4'b0000, "t3_stall");
    credit_in = 2'b10;
    cycle(4'b0000, "t3_stall_credit");
    credit_in = 2'b00;
    push_exp(1'b1, 1'b0, 1'b0, 32'hC100_0002);
    cycle(4'b0010, "t3_one_flit");
    set_req(1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC100_0003);
    cycle(4'b0000, "t3_stall_again");
    credit_in = 2'b10;
    cycle(4'b0000, "t3_stall_credit2");
    credit_in = 2'b00;
    push_exp(1'b1, 1'b0, 1'b1, 32'hC100_0003);
    cycle(4'b0010, "t3_tail");
    clr_req(1);
    check("t3_state_idle", dbg_state_o, IDLE);
    check("t3_credit_end", dbg_credit_o, 6'o03);
    credit_in = 2'b11;
    cycle(4'b0000, "t3_restore_a");
    credit_in = 2'b10;
    for (int k = 0; k < 3; k++) cycle(4'b0000, "t3_restore_b");
    credit_in = 2'b00;
    check("t3_credit_full", dbg_credit_o, 6'o44);
    check("t3_err", err_o, 1'b0);

    // Simultaneous send and credit return at credit 2; overflow at B.
    set_req(3, 1'b1, 1'b1, 1'b1, 1'b0, 32'hD300_0001);
    push_exp(1'b0, 1'b1, 1'b1, 32'hD300_0001);
    cycle(4'b1000, "t4_a");
    set_req(3, 1'b1, 1'b1, 1'b1, 1'b0, 32'hD300_0002);
    push_exp(1'b0, 1'b1, 1'b1, 32'hD300_0002);
    cycle(4'b1000, "t4_b");
    clr_req(3);
    check("t4_credit2", dbg_credit_o, 6'o42);
    set_req(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hD000_0001);
    push_exp(1'b0, 1'b1, 1'b1, 32'hD000_0001);
    credit_in = 2'b01;
    cycle(4'b0001, "t4_same_cycle");
    clr_req(0);
    credit_in = 2'b00;
    check("t4_credit_same", dbg_credit_o, 6'o42);
    credit_in = 2'b01;
    cycle(4'b0000, "t4_ret_a");
    cycle(4'b0000, "t4_ret_b");
    credit_in = 2'b00;
    check("t4_credit_full", dbg_credit_o, 6'o44);
    check("t4_err_before", err_o, 1'b0);
    credit_in = 2'b01;
    cycle(4'b0000, "t4_overflow");
    credit_in = 2'b00;
    check("t4_err_overflow", err_o, 1'b1);
    check("t4_credit_sat", dbg_credit_o, 6'o44);

    // Non-header in IDLE, then reset applied in LOCK.
    reset = 1'b1;
    cycle(4'b0000, "t5_reset");
    reset = 1'b0;
    check("t5_err_clr", err_o, 1'b0);
    set_req(1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hE100_0001);
    cycle(4'b0000, "t5_nonhdr");
    clr_req(1);
    check("t5_err_nonhdr", err_o, 1'b1);
    reset = 1'b1;
    cycle(4'b0000, "t5_reset2");
    reset = 1'b0;
    set_req(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hE000_0001);
    set_req(3, 1'b1, 1'b1, 1'b0, 1'b0, 32'hE300_0001);
    push_exp(1'b0, 1'b1, 1'b1, 32'hE000_0001);
    cycle(4'b0001, "t5_ptr_reset");
    clr_req(0);
    push_exp(1'b0, 1'b1, 1'b0, 32'hE300_0001);
    cycle(4'b1000, "t5_lock_hdr");
    check("t5_state_lock", dbg_state_o, LOCK);
    check("t5_credit_lock", dbg_credit_o, 6'o42);
    set_req(3, 1'b1, 1'b0, 1'b0, 1'b0, 32'hE300_0002);
    reset = 1'b1;
    cycle(4'b0000, "t5_reset_lock");
    clr_req(3);
    reset = 1'b0;
    check("t5_state_after", dbg_state_o, IDLE);
    check("t5_credit_after", dbg_credit_o, 6'o44);
    check("t5_flit_wr_after", flit_wr, 1'b0);
    cycle(4'b0000, "t5_quiet");
    check("t5_flit_wr_quiet", flit_wr, 1'b0);
    check("t5_err_after", err_o, 1'b0);

`ifdef NOC_INJ_ARB_STATS_EN
    // Packet counters: 5 from requester 1, 2 from requester 3.
    reset = 1'b1;
    cycle(4'b0000, "t6_reset");
    reset = 1'b0;
    credit_in = 2'b01;
    for (int k = 0; k < 5; k++) begin
      set_req(1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hF100_0000 + k);
      push_exp(1'b0, 1'b1, 1'b1, 32'hF100_0000 + k);
      cycle(4'b0010, "t6_req1");
    end
    clr_req(1);
    for (int k = 0; k < 2; k++) begin
      set_req(3, 1'b1, 1'b1, 1'b1, 1'b0, 32'hF300_0000 + k);
      push_exp(1'b0, 1'b1, 1'b1, 32'hF300_0000 + k);
      cycle(4'b1000, "t6_req3");
    end
    clr_req(3);
    credit_in = 2'b00;
    check("t6_cnt0", pkt_cnt[31:0], 32'd0);
    check("t6_cnt1", pkt_cnt[63:32], 32'd5);
    check("t6_cnt2", pkt_cnt[95:64], 32'd0);
    check("t6_cnt3", pkt_cnt[127:96], 32'd2);
`endif

    // Drain and report.
    for (int k = 0; k < 3; k++) cycle(4'b0000, "drain");
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/noc_inj_arbiter.md
NOC_INJ_ARBITER -- requirements
Module: noc_inj_arbiter

Interface
REQ-001 SHALL have parameter NOC_ID, default 0; selects the NoC configuration that supplies the flit width Fw and the VC count V.
REQ-002 SHALL have parameter NREQ, default 4; the number of requesters sharing one endpoint injection port (2..16).
REQ-003 SHALL have parameter B, default 4; the per-VC input buffer depth of the attached router local port.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NREQ  requester i presents a flit.
REQ-007 req_hdr, req_tail  in  NREQ each  header/tail markers per requester.
REQ-008 req_vc  in  NREQ x log2(V)  target VC index per requester.
REQ-009 req_data  in  NREQ x Fw  flit payload per requester.
REQ-010 req_ready  out  NREQ  flit of requester i accepted this cycle.
REQ-011 flit_wr  out  1  flit valid toward the router local port.
REQ-012 flit_out  out  Fw  flit payload; flit_hdr_o, flit_tail_o  out  1 each.
REQ-013 flit_vc  out  V  one-hot VC of flit_out.
REQ-014 credit_in  in  V  one-hot credit return from the router, one per freed buffer slot.
REQ-015 err_o  out  1  sticky protocol error.

Function
REQ-016 SHALL implement FSM {IDLE, LOCK}.
REQ-017 IDLE: eligible(i) = req_valid[i] & req_hdr[i] & credit[req_vc[i]] > 0; among eligible requesters, SHALL grant round-robin starting at the requester after the last one granted.
REQ-018 A grant in IDLE SHALL assert req_ready[grant] in the same cycle.
REQ-019 If the granted flit has its tail bit clear, the FSM SHALL go to LOCK and record the owner and VC.
REQ-020 A single-flit packet (hdr & tail) SHALL leave the FSM in IDLE.
REQ-021 LOCK: only the owner may be accepted; req_ready[owner] = req_valid[owner] & credit[locked VC] > 0. Acceptance of a tail flit SHALL return the FSM to IDLE in the next cycle.
REQ-022 At most one req_ready bit SHALL be set per cycle.
REQ-023 Output SHALL be registered: an accepted flit appears on flit_wr/flit_out/flit_vc exactly one cycle after req_ready.
REQ-024 Per-VC credit counter (width log2(B+1)): decrement on send, increment on credit_in; when both occur in the same cycle the counter is unchanged.
REQ-025 A counter at B receiving credit_in, or at 0 being decremented, SHALL set err_o; the counter saturates.
REQ-026 In IDLE, a valid flit without hdr SHALL NOT be accepted and SHALL set err_o.
REQ-027 In LOCK, a flit from the owner with hdr set SHALL set err_o and SHALL still be forwarded.
REQ-028 The round-robin pointer SHALL update only on a header grant.

Reset
REQ-029 On reset: FSM=IDLE, credits=B, rr pointer=0 (requester 0 has highest priority), flit_wr=0, flit_out=0, flit_vc=0, req_ready=0, err_o=0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; no partial flit is emitted after reset.

Configuration
REQ-031 With NOC_INJ_ARB_STATS_EN defined, the block SHALL add output pkt_cnt (NREQ x 32) giving the number of packets granted per requester; counts increment on header grant, wrap at 2^32, and clear on reset.
REQ-032 Without NOC_INJ_ARB_STATS_EN, the pkt_cnt port and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-033 The FSM state type inj_arb_state_t SHALL be defined in pronoc_pkg; Fw and V SHALL come from the NoC configuration selected by NOC_ID.
REQ-034 Round-robin selection SHALL be a sub-module inj_rr_arbiter (NREQ request in, one-hot grant out, pointer update enable).

Verification
REQ-035 Reset, then all four requesters present single-flit headers on VC0, B=4 -> grants 0,1,2,3, then stall with credit=0; flits out at cycles +1..+4.
REQ-036 Requester 2 sends a 3-flit packet; requester 0 is valid from flit 2 onward -> requester 0 is not ready until the cycle after requester 2's tail is accepted.
REQ-037 Credit for VC1 reaches 0 mid-packet in LOCK -> req_ready deasserts; after one credit_in[1] pulse, exactly one flit proceeds.
REQ-038 Send and credit_in occur in the same cycle on VC0 at credit=2 -> credit stays 2; credit_in with credit=B -> err_o=1 and credit stays at B.
REQ-039 Non-header flit presented in IDLE -> req_ready=0, err_o=1; reset applied in LOCK -> IDLE, credits=B, no output flit.
REQ-040 With NOC_INJ_ARB_STATS_EN: 5 packets from requester 1 and 2 from requester 3 -> pkt_cnt[1]=5, pkt_cnt[3]=2, others 0.
